alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 6-bit function code produced by the ALU control block and performs the operation.
- Single-cycle ops (add/sub/logic/slt/shift/HI-LO moves) return a registered result 1 cycle after acceptance.
- mult/multu/div/divu run on an iterative FSM that writes the HI/LO registers; o_ready stalls the pipeline while the FSM is busy.

Parameters:
- SIZE, 32, operand/result width.
- ALU_FUNC_SIZE, 6, function code width.
- SHAMT_SIZE, 5, shift amount width; must equal log2(SIZE).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_flush  input  1  synchronous abort of the accepted/in-flight op.
- i_valid  input  1  operation presented.
- o_ready  output  1  unit can accept this cycle.
- i_func  input  ALU_FUNC_SIZE  function code.
- i_a  input  SIZE  operand A (rs).
- i_b  input  SIZE  operand B (rt).
- i_shamt  input  SHAMT_SIZE  shift amount.
- o_valid  output  1  result valid, 1-cycle pulse.
- o_result  output  SIZE  result.
- o_overflow  output  1  signed add/sub overflow, qualified by o_valid.
- o_zero  output  1  o_result == 0, qualified by o_valid.
- o_illegal  output  1  unrecognised func, qualified by o_valid.
- o_hi  output  SIZE  HI register.
- o_lo  output  SIZE  LO register.

Behaviour:
- Reset (async, i_rst_n low): FSM=IDLE; HI=LO=0; o_valid/o_overflow/o_zero/o_illegal=0; o_result=0; o_ready=1 once reset is released.
- Handshake: op accepted when i_valid && o_ready. o_ready=1 only in IDLE.
- Single-cycle ops: o_valid pulses at cycle N+1 for acceptance at N. Back-to-back acceptance every cycle is allowed.
- Func codes:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101000 slt (signed), 101001 sltu: result 1 or 0.
  - 000000 sll, 000010 srl, 000011 sra: shift i_b by i_shamt.
  - 000100 sllv, 000110 srlv, 000111 srav: shift i_b by i_a[SHAMT_SIZE-1:0].
  - 010000 mfhi, 010010 mflo: result=HI/LO. 010001 mthi, 010011 mtlo: HI/LO<=i_a, result=i_a.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
- add/sub: result always wraps modulo 2^SIZE. o_overflow=1 only for add/sub on signed overflow (operands of equal sign for add, opposite sign for sub, result sign differs from A). addu/subu never flag.
- Unknown func: single-cycle, result=0, o_illegal=1, no state change.
- FSM states:
  - IDLE: accept. mult/div moves to MUL or DIV with counter=0 and o_ready=0.
  - MUL: shift-add, 1 bit per cycle, SIZE cycles. Signed ops use operand magnitudes with the sign fixed at the end.
  - DIV: restoring divide, 1 quotient bit per cycle, SIZE cycles.
  - DONE: write HI/LO; pulse o_valid with o_result=LO and o_zero from LO; next state IDLE.
- Mult/div latency: acceptance at N, o_valid at N+SIZE+1, o_ready high again at N+SIZE+2.
- mult/multu result: {HI,LO} = full 2*SIZE-bit product.
- div/divu result: LO=quotient, HI=remainder. Signed div truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: no fault; LO=all ones, HI=i_a. DIV state still takes SIZE cycles.
- Signed div of most-negative by -1: LO=most-negative, HI=0, no flag.
- i_flush:
  - In MUL/DIV: next state IDLE, no o_valid, HI/LO unchanged.
  - In the cycle after a single-cycle acceptance: suppresses o_valid; mthi/mtlo effects are still committed.
  - i_flush concurrent with i_valid in IDLE: op is not accepted.
- Async reset mid-MUL/DIV: immediate return to IDLE, HI=LO=0.
- o_hi/o_lo update only in DONE or on mthi/mtlo acceptance.

Test Plan:
- add 0x7FFFFFFF+0x00000001 -> o_result=0x80000000, o_overflow=1. Same operands with addu -> o_overflow=0.
- slt a=0xFFFFFFFF, b=1 -> result=1. sltu same operands -> result=0. sra b=0x80000000, shamt=4 -> 0xF8000000.
- mult a=0xFFFFFFFE(-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. o_valid exactly 33 cycles after acceptance; o_ready=0 throughout; following mfhi returns 0xFFFFFFFF.
- div a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- divu started, i_flush at cycle 10 -> no o_valid, HI/LO retain prior values, o_ready=1 next cycle. Repeat with i_rst_n low at cycle 10 -> HI=LO=0, o_ready=1 after release.
- Back-to-back and/or/xor/nor on 0xF0F0F0F0, 0x0FF00FF0 -> results 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0x000F000F on 4 consecutive cycles. func=111111 -> o_illegal=1, result=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with registered results, plus an iterative
// shift-add multiplier / restoring divider that owns the HI/LO registers.
module alu_exec_unit #(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned ALU_FUNC_SIZE = 6,
  parameter int unsigned SHAMT_SIZE    = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ALU_FUNC_SIZE-1:0] i_func,
  input  logic [SIZE-1:0]          i_a,
  input  logic [SIZE-1:0]          i_b,
  input  logic [SHAMT_SIZE-1:0]    i_shamt,
  output logic                     o_valid,
  output logic [SIZE-1:0]          o_result,
  output logic                     o_overflow,
  output logic                     o_zero,
  output logic                     o_illegal,
  output logic [SIZE-1:0]          o_hi,
  output logic [SIZE-1:0]          o_lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic [SHAMT_SIZE-1:0] cnt_q;
  logic [SIZE-1:0]       work_hi_q, work_lo_q, opb_q, a_q;
  logic                  neg_q, rneg_q, dz_q;
  logic [SIZE-1:0]       hi_q, lo_q, result_q;
  logic                  valid_q, ovf_q, zero_q, ill_q;

  logic [SIZE-1:0] sc_res, sum, diff, a_mag, b_mag;
  logic            sc_ovf, sc_ill, sc_wr_hi, sc_wr_lo;
  logic            is_mdu, mdu_div, mdu_signed, a_neg, b_neg;
  logic            accept, last, done, sc_out;

  assign o_ready = (state_q == StIdle);
  assign accept  = i_valid && o_ready && !i_flush;
  assign last    = (cnt_q == SHAMT_SIZE'(SIZE - 1));
  assign done    = (state_q == StDone);
  assign sum     = i_a + i_b;
  assign diff    = i_a - i_b;

  always_comb begin
    sc_res     = '0;
    sc_ovf     = 1'b0;
    sc_ill     = 1'b0;
    sc_wr_hi   = 1'b0;
    sc_wr_lo   = 1'b0;
    is_mdu     = 1'b0;
    mdu_div    = 1'b0;
    mdu_signed = 1'b0;
    case (i_func)
      6'b100000: begin
        sc_res = sum;
        sc_ovf = (i_a[SIZE-1] == i_b[SIZE-1]) && (sum[SIZE-1] != i_a[SIZE-1]);
      end
      6'b100001: sc_res = sum;
      6'b100010: begin
        sc_res = diff;
        sc_ovf = (i_a[SIZE-1] != i_b[SIZE-1]) && (diff[SIZE-1] != i_a[SIZE-1]);
      end
      6'b100011: sc_res = diff;
      6'b100100: sc_res = i_a & i_b;
      6'b100101: sc_res = i_a | i_b;
      6'b100110: sc_res = i_a ^ i_b;
      6'b100111: sc_res = ~(i_a | i_b);
      6'b101000: sc_res = {{(SIZE-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      6'b101001: sc_res = {{(SIZE-1){1'b0}}, (i_a < i_b)};
      6'b000000: sc_res = i_b << i_shamt;
      6'b000010: sc_res = i_b >> i_shamt;
      6'b000011: sc_res = $signed(i_b) >>> i_shamt;
      6'b000100: sc_res = i_b << i_a[SHAMT_SIZE-1:0];
      6'b000110: sc_res = i_b >> i_a[SHAMT_SIZE-1:0];
      6'b000111: sc_res = $signed(i_b) >>> i_a[SHAMT_SIZE-1:0];
      6'b010000: sc_res = hi_q;
      6'b010010: sc_res = lo_q;
      6'b010001: begin
        sc_res   = i_a;
        sc_wr_hi = 1'b1;
      end
      6'b010011: begin
        sc_res   = i_a;
        sc_wr_lo = 1'b1;
      end
      6'b011000: begin
        is_mdu     = 1'b1;
        mdu_signed = 1'b1;
      end
      6'b011001: is_mdu = 1'b1;
      6'b011010: begin
        is_mdu     = 1'b1;
        mdu_div    = 1'b1;
        mdu_signed = 1'b1;
      end
      6'b011011: begin
        is_mdu  = 1'b1;
        mdu_div = 1'b1;
      end
      default: sc_ill = 1'b1;
    endcase
  end

  // Signed mult/div iterate on magnitudes; signs are re-applied on the last step.
  assign a_neg = mdu_signed && i_a[SIZE-1];
  assign b_neg = mdu_signed && i_b[SIZE-1];
  assign a_mag = a_neg ? -i_a : i_a;
  assign b_mag = b_neg ? -i_b : i_b;

  logic [SIZE:0]     mul_sum, div_shift, div_trial;
  logic [2*SIZE-1:0] mul_next, mul_fin;
  logic [SIZE-1:0]   div_rem, div_quo, quo_fin, rem_fin;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + {1'b0, opb_q & {SIZE{work_lo_q[0]}}};
    mul_next  = {mul_sum, work_lo_q[SIZE-1:1]};
    mul_fin   = neg_q ? -mul_next : mul_next;
    div_shift = {work_hi_q, work_lo_q[SIZE-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_ge    = !div_trial[SIZE];
    div_rem   = div_ge ? div_trial[SIZE-1:0] : div_shift[SIZE-1:0];
    div_quo   = {work_lo_q[SIZE-2:0], div_ge};
    quo_fin   = dz_q ? '1 : (neg_q ? -div_quo : div_quo);
    rem_fin   = dz_q ? a_q : (rneg_q ? -div_rem : div_rem);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && is_mdu) state_d = mdu_div ? StDiv : StMul;
      StMul, StDiv: begin
        if (i_flush)   state_d = StIdle;
        else if (last) state_d = StDone;
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opb_q     <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else if (accept && is_mdu) begin
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= a_mag;
      opb_q     <= b_mag;
      a_q       <= i_a;
      neg_q     <= a_neg ^ b_neg;
      rneg_q    <= a_neg;
      dz_q      <= (i_b == '0);
    end else if (state_q == StMul) begin
      cnt_q <= cnt_q + SHAMT_SIZE'(1);
      {work_hi_q, work_lo_q} <= last ? mul_fin : mul_next;
    end else if (state_q == StDiv) begin
      cnt_q     <= cnt_q + SHAMT_SIZE'(1);
      work_hi_q <= last ? rem_fin : div_rem;
      work_lo_q <= last ? quo_fin : div_quo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (done) begin
        hi_q <= work_hi_q;
        lo_q <= work_lo_q;
      end else if (accept) begin
        if (sc_wr_hi) hi_q <= i_a;
        if (sc_wr_lo) lo_q <= i_a;
      end
      valid_q <= accept && !is_mdu;
      if (accept && !is_mdu) begin
        result_q <= sc_res;
        ovf_q    <= sc_ovf;
        zero_q   <= (sc_res == '0);
        ill_q    <= sc_ill;
      end
    end
  end

  // A flush in the cycle after acceptance only hides the result; HI/LO writes stand.
  assign sc_out     = valid_q && !i_flush;
  assign o_valid    = done || sc_out;
  assign o_result   = done ? work_lo_q : result_q;
  assign o_zero     = done ? (work_lo_q == '0) : (sc_out && zero_q);
  assign o_overflow = sc_out && ovf_q;
  assign o_illegal  = sc_out && ill_q;
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;

endmodule
